// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word-aligned imem requests, buffers
// in-order responses in a small FIFO and presents them to decode through a stall-able register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        decode_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        instr_valid
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DEPTH_W = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_X = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_next;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic          fifo_empty;
  logic          req_fire;
  logic          resp_drop;
  logic          push;
  logic          load;
  logic [31:0]   redirect_base;
  logic          unused_redirect_bits;

  // Handshakes: a transfer happens on a rising edge where valid && ready; the request
  // side keeps valid/addr stable until accepted, except that a redirect withdraws it.
  assign fifo_count     = wr_ptr - rd_ptr;
  assign fifo_empty     = (fifo_count == '0);
  assign imem_req_valid = reset_n && !redirect_valid &&
                          (({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_X);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_drop      = redirect_valid || (drop_cnt != '0);
  assign push           = imem_resp_valid && !resp_drop;
  assign load           = !instr_valid || decode_ready;
  assign inflight_next  = inflight + {{AW{1'b0}}, req_fire} - {{AW{1'b0}}, imem_resp_valid};
  assign redirect_base  = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_bits = ^redirect_pc[1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      inflight    <= '0;
      drop_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      instr_valid <= 1'b0;
      instruction <= NOP_INSTR;
      pc_out      <= '0;
    end else begin
      inflight <= inflight_next;
      if (redirect_valid) begin
        // Everything still outstanding after this edge belongs to the old path.
        fetch_pc    <= redirect_base;
        resp_pc     <= redirect_base;
        drop_cnt    <= inflight_next;
        rd_ptr      <= wr_ptr;
        instr_valid <= 1'b0;
        instruction <= NOP_INSTR;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - ONE;
        if (push) begin
          wr_ptr  <= wr_ptr + ONE;
          resp_pc <= resp_pc + 32'd4;
        end
        if (load) begin
          if (!fifo_empty) begin
            instruction <= fifo_data[rd_ptr[AW-1:0]];
            pc_out      <= fifo_pc[rd_ptr[AW-1:0]];
            instr_valid <= 1'b1;
            rd_ptr      <= rd_ptr + ONE;
          end else begin
            instr_valid <= 1'b0;
            instruction <= NOP_INSTR;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_ptr[AW-1:0]] <= imem_resp_data;
      fifo_pc[wr_ptr[AW-1:0]]   <= resp_pc;
    end
  end

  // The issue credit must keep the buffer from ever being pushed while full.
  assert property (@(posedge clock) disable iff (!reset_n) !(push && (fifo_count == DEPTH_W)));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: an in-order memory model feeds responses,
// a queue of expected {pc, instruction} pairs is checked by an independent monitor.
module tb_fetch_stage;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        decode_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        instr_valid;

  fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .decode_ready(decode_ready), .instruction(instruction), .pc_out(pc_out), .instr_valid(instr_valid)
  );

  // clock
  always #5 clock = ~clock;

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  req_t        pend_q[$];
  logic [63:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          epoch = 0;
  logic [31:0] model_pc = RESET_PC;
  bit          model_out = 1'b0;
  int          p_ready = 100, p_resp = 100, p_dec = 100, p_redir = 0, max_lat = 0;
  int          first_resp_cyc = -1, first_valid_cyc = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h002081B3;
      32'h4:   return 32'h00418233;
      32'h8:   return 32'h00628293;
      default: return (a * 32'h9E3779B1) ^ 32'h0000_0013;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // driver + memory model: inputs change on negedge, this cycle's events are settled at +1
  task automatic step(input bit force_redir, input logic [31:0] rpc);
    req_t r;
    int   fifo_cnt;
    bit   next_out;
    bit   exp_req;
    @(negedge clock);
    cyc++;
    imem_req_ready = ($urandom_range(99) < p_ready);
    decode_ready   = ($urandom_range(99) < p_dec);
    redirect_valid = force_redir || ($urandom_range(999) < p_redir);
    redirect_pc    = force_redir ? rpc : $urandom;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc && $urandom_range(99) < p_resp) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend_q[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    #1;
    fifo_cnt = exp_q.size() - int'(model_out);
    exp_req  = !redirect_valid && (pend_q.size() + fifo_cnt < DEPTH);
    check("req_valid", 64'(imem_req_valid), 64'(exp_req));
    if (imem_req_valid) check("req_addr", 64'(imem_req_addr), 64'(model_pc));
    next_out = (!model_out || decode_ready) ? (fifo_cnt > 0) : 1'b1;
    if (imem_req_valid && imem_req_ready) begin
      pend_q.push_back('{model_pc, epoch, cyc + 1 + $urandom_range(max_lat)});
      model_pc += 32'd4;
    end
    if (imem_resp_valid) begin
      r = pend_q.pop_front();
      if (first_resp_cyc < 0) first_resp_cyc = cyc;
      if (!redirect_valid && r.epoch == epoch) exp_q.push_back({r.addr, mem_word(r.addr)});
    end
    #2;
    if (redirect_valid) begin
      exp_q.delete();
      epoch++;
      model_pc  = {redirect_pc[31:2], 2'b00};
      model_out = 1'b0;
    end else begin
      model_out = next_out;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  // monitor: compares what decode sees against the scoreboard queue
  always @(negedge clock) begin
    logic [63:0] e;
    #2;
    if (reset_n) begin
      check("instr_valid", 64'(instr_valid), 64'(model_out));
      if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (!instr_valid) check("nop_instr", 64'(instruction), 64'(NOP));
      if (instr_valid && decode_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr cycle %0d: got %h/%h expected none", cyc, pc_out, instruction);
        end else begin
          e = exp_q.pop_front();
          check("pc_instr", {pc_out, instruction}, e);
        end
      end
    end
  end

  initial begin
    // reset values
    #12;
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instruction), 64'(NOP));
    check("rst_pc_out", 64'(pc_out), 64'd0);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // streaming, 1-cycle memory, decode always ready
    run(8);
    check("first_valid_latency", 64'(first_valid_cyc - first_resp_cyc), 64'd2);

    // decode stall with memory streaming, then release
    p_dec = 0;
    run(6);
    p_dec = 100;
    run(10);

    // memory not ready for 3 cycles
    p_ready = 0;
    run(3);
    p_ready = 100;
    run(5);

    // redirect to 0x103 with two requests in flight
    p_resp = 0;
    for (int i = 0; i < 20 && pend_q.size() < 2; i++) step(1'b0, '0);
    check("setup_two_inflight", 64'(pend_q.size() >= 2), 64'd1);
    step(1'b1, 32'h0000_0103);
    p_resp = 100;
    max_lat = 2;
    run(12);

    // redirect coinciding with a response while decode is stalled
    p_dec = 0;
    run(2);
    for (int i = 0; i < 20 && !(pend_q.size() > 0 && pend_q[0].due <= cyc + 1); i++) step(1'b0, '0);
    check("setup_resp_due", 64'(pend_q.size() > 0 && pend_q[0].due <= cyc + 1), 64'd1);
    step(1'b1, 32'h0000_0040);
    p_dec = 100;
    run(10);

    // PC wrap and randomized traffic with occasional redirects
    step(1'b1, 32'hFFFF_FFF9);
    run(8);
    p_ready = 70; p_resp = 60; p_dec = 60; p_redir = 20; max_lat = 4;
    run(3000);

    // asynchronous reset between clock edges
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; redirect_valid = 1'b0; decode_ready = 1'b0;
    #1;
    check("midrst_valid", 64'(instr_valid), 64'd0);
    check("midrst_instr", 64'(instruction), 64'(NOP));
    check("midrst_req_valid", 64'(imem_req_valid), 64'd0);
    pend_q.delete();
    exp_q.delete();
    model_out = 1'b0;
    model_pc = RESET_PC;
    epoch++;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    run(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
